// File: rtl/axi_read_responder.sv
// ---------------------------------------------------------------------------
// axi_read_responder
//
// Read-channel memory backend for the cache refill engines. Burst requests
// arriving on the read-address channel are queued in a small FIFO, then an
// engine replays each burst beat by beat from an internal word-addressed
// memory after a programmable first-beat latency. A sideband preload port
// writes the memory at any time and the contents survive reset.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   ARADDR/ARLEN/ARID    request: byte address, beat count (0 means 1), tag
//   ARVALID/ARREADY      request handshake
//   RDATA/RID/RLAST      beat data, burst tag, final-beat flag
//   RVALID/RREADY        beat handshake
//   pl_we/pl_addr/pl_wdata  preload write port (word address)
// ---------------------------------------------------------------------------
module axi_read_responder #(
   parameter int MEM_INDEX_WIDTH = 14,
   parameter int LATENCY         = 2,
   parameter int REQ_DEPTH       = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [31:0]                ARADDR,
   input  logic [7:0]                 ARLEN,
   input  logic [3:0]                 ARID,
   input  logic                       ARVALID,
   output logic                       ARREADY,
   output logic [31:0]                RDATA,
   output logic [3:0]                 RID,
   output logic                       RLAST,
   output logic                       RVALID,
   input  logic                       RREADY,
   input  logic                       pl_we,
   input  logic [MEM_INDEX_WIDTH-1:0] pl_addr,
   input  logic [31:0]                pl_wdata
);

   localparam int PTR_W = (REQ_DEPTH > 1) ? $clog2(REQ_DEPTH) : 1;
   localparam int CNT_W = $clog2(REQ_DEPTH + 1);
   localparam int LAT_W = (LATENCY > 1) ? $clog2(LATENCY + 1) : 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_WAIT  = 2'd1;
   localparam logic [1:0] S_BURST = 2'd2;

   logic [31:0]                mem [2**MEM_INDEX_WIDTH];

   logic [MEM_INDEX_WIDTH-1:0] fifo_addr  [REQ_DEPTH];
   logic [7:0]                 fifo_beats [REQ_DEPTH];
   logic [3:0]                 fifo_id    [REQ_DEPTH];
   logic [PTR_W-1:0]           wr_ptr;
   logic [PTR_W-1:0]           rd_ptr;
   logic [CNT_W-1:0]           fifo_count;

   logic [1:0]                 state;
   logic [LAT_W-1:0]           lat_cnt;
   logic [MEM_INDEX_WIDTH-1:0] cur_addr;
   logic [MEM_INDEX_WIDTH-1:0] next_addr;
   logic [7:0]                 beats_left;
   logic [3:0]                 burst_id;
   logic [31:0]                rdata_q;

   logic                       push;
   logic                       pop;
   logic                       last_beat;
   logic                       unused_araddr;

   // Only the word-index bits of the byte address reach the memory.
   assign unused_araddr = ^{ARADDR[31:MEM_INDEX_WIDTH+2], ARADDR[1:0]};

   // Pointer advance; power-of-two depth lets the counter wrap on its own,
   // a single-entry FIFO keeps its pointer pinned at zero.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      if (REQ_DEPTH == 1) return '0;
      else                return p + PTR_W'(1);
   endfunction

   // Acceptance depends on occupancy alone, so a full FIFO stays closed even
   // in the cycle the engine pops it.
   assign ARREADY   = ~rst & (fifo_count < CNT_W'(REQ_DEPTH));
   assign push      = ARVALID & ARREADY;
   assign pop       = (state == S_IDLE) && (fifo_count != '0);
   assign last_beat = (beats_left == 8'd1);
   assign next_addr = cur_addr + MEM_INDEX_WIDTH'(1);

   assign RVALID = (state == S_BURST);
   assign RLAST  = RVALID & last_beat;
   assign RID    = burst_id;
   assign RDATA  = rdata_q;

   // Preload port; kept out of reset so memory contents persist.
   always_ff @(posedge clk) begin
      if (pl_we) mem[pl_addr] <= pl_wdata;
   end

   // Request FIFO payload. A zero beat count is stored as a single beat.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_addr[wr_ptr]  <= ARADDR[MEM_INDEX_WIDTH+1:2];
         fifo_beats[wr_ptr] <= (ARLEN == 8'd0) ? 8'd1 : ARLEN;
         fifo_id[wr_ptr]    <= ARID;
      end
   end

   // Request FIFO pointers and occupancy; reset flushes all queued requests.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         if (push && !pop)      fifo_count <= fifo_count + CNT_W'(1);
         else if (pop && !push) fifo_count <= fifo_count - CNT_W'(1);
      end
   end

   // Burst engine. RDATA is registered: the first word is fetched when the
   // engine enters BURST and each handshake pre-fetches the following word,
   // so the beat on the bus never changes while the consumer stalls. A
   // preload to the word being fetched in the same edge yields the old data.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         lat_cnt    <= '0;
         cur_addr   <= '0;
         beats_left <= '0;
         burst_id   <= '0;
         rdata_q    <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (pop) begin
                  cur_addr   <= fifo_addr[rd_ptr];
                  beats_left <= fifo_beats[rd_ptr];
                  burst_id   <= fifo_id[rd_ptr];
                  lat_cnt    <= LAT_W'(LATENCY);
                  if (LATENCY == 0) begin
                     state   <= S_BURST;
                     rdata_q <= mem[fifo_addr[rd_ptr]];
                  end else begin
                     state   <= S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               lat_cnt <= lat_cnt - LAT_W'(1);
               if (lat_cnt <= LAT_W'(1)) begin
                  state   <= S_BURST;
                  rdata_q <= mem[cur_addr];
               end
            end
            S_BURST: begin
               if (RREADY) begin
                  cur_addr   <= next_addr;
                  beats_left <= beats_left - 8'd1;
                  rdata_q    <= mem[next_addr];
                  if (last_beat) state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_read_responder.sv
// ---------------------------------------------------------------------------
// tb_axi_read_responder
//
// Directed bench. Each issued request pushes its expected beats (data, tag,
// last flag, and the cycle its first beat should appear) into a scoreboard
// queue; a monitor on the falling edge pops and compares on every beat. A
// second instance built with zero latency checks the shortest turnaround.
// ---------------------------------------------------------------------------
module tb_axi_read_responder;

   localparam int MW  = 14;
   localparam int LAT = 2;

   typedef struct {
      logic [31:0] data;
      logic [3:0]  id;
      logic        last;
      logic        first;
      int          ar_cyc;
   } beat_t;

   logic          clk = 1'b0;
   logic          rst;
   logic [31:0]   ARADDR;
   logic [7:0]    ARLEN;
   logic [3:0]    ARID;
   logic          ARVALID;
   logic          ARREADY;
   logic [31:0]   RDATA;
   logic [3:0]    RID;
   logic          RLAST;
   logic          RVALID;
   logic          RREADY;
   logic          pl_we;
   logic [MW-1:0] pl_addr;
   logic [31:0]   pl_wdata;

   logic [31:0]   ar0_addr;
   logic [7:0]    ar0_len;
   logic [3:0]    ar0_id;
   logic          ar0_valid;
   logic          ar0_ready;
   logic [31:0]   r0_data;
   logic [3:0]    r0_id;
   logic          r0_last;
   logic          r0_valid;
   logic          r0_ready;

   logic [31:0]   model_mem [2**MW];
   beat_t         sb [$];
   int            cyc = 0;
   int            hs_count = 0;
   int            last_rlast = -100;
   bit            in_burst = 0;
   int            n_checks = 0;
   int            n_fail = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   axi_read_responder #(.MEM_INDEX_WIDTH(MW), .LATENCY(LAT), .REQ_DEPTH(2)) u_dut (
      .clk(clk), .rst(rst),
      .ARADDR(ARADDR), .ARLEN(ARLEN), .ARID(ARID), .ARVALID(ARVALID), .ARREADY(ARREADY),
      .RDATA(RDATA), .RID(RID), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
      .pl_we(pl_we), .pl_addr(pl_addr), .pl_wdata(pl_wdata)
   );

   axi_read_responder #(.MEM_INDEX_WIDTH(MW), .LATENCY(0), .REQ_DEPTH(2)) u_dut0 (
      .clk(clk), .rst(rst),
      .ARADDR(ar0_addr), .ARLEN(ar0_len), .ARID(ar0_id), .ARVALID(ar0_valid), .ARREADY(ar0_ready),
      .RDATA(r0_data), .RID(r0_id), .RLAST(r0_last), .RVALID(r0_valid), .RREADY(r0_ready),
      .pl_we(pl_we), .pl_addr(pl_addr), .pl_wdata(pl_wdata)
   );

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Writes both DUT memories (shared preload bus) and the reference copy.
   task automatic preload(input logic [MW-1:0] a, input logic [31:0] d);
      pl_we    = 1'b1;
      pl_addr  = a;
      pl_wdata = d;
      model_mem[a] = d;
      @(posedge clk); #1;
      pl_we    = 1'b0;
   endtask

   // Issues one request, waits (bounded) for acceptance and queues its beats.
   task automatic applyStimulus(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] id);
      int      waited;
      int      beats;
      beat_t   b;
      logic [MW-1:0] w;
      ARADDR  = addr;
      ARLEN   = len;
      ARID    = id;
      ARVALID = 1'b1;
      waited  = 0;
      @(negedge clk);
      while (!ARREADY && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      if (!ARREADY) begin
         checkOutput("ar_accept_timeout", 32'(ARREADY), 32'd1);
      end else begin
         beats = (len == 8'd0) ? 1 : int'(len);
         w = addr[MW+1:2];
         for (int i = 0; i < beats; i++) begin
            b.data   = model_mem[w + MW'(i)];
            b.id     = id;
            b.last   = (i == beats - 1);
            b.first  = (i == 0);
            b.ar_cyc = cyc;
            sb.push_back(b);
         end
      end
      @(posedge clk); #1;
      ARVALID = 1'b0;
   endtask

   task automatic waitDrain();
      int n = 0;
      while ((sb.size() != 0 || RVALID) && n < 500) begin
         @(posedge clk); #1;
         n++;
      end
      checkOutput("drain_pending_beats", 32'(sb.size()), 32'd0);
   endtask

   // Monitor: every visible beat is compared with the scoreboard head, so a
   // stalled beat is checked each cycle it is held. First-beat timing is
   // max(request cycle, previous RLAST cycle) + 2 + LAT. Reset flushes all.
   always @(negedge clk) begin
      beat_t head;
      int    exp_cyc;
      if (rst) begin
         sb.delete();
         in_burst = 0;
      end else if (RVALID) begin
         if (sb.size() == 0) begin
            checkOutput("unexpected_rvalid", 32'(RVALID), 32'd0);
         end else begin
            head = sb[0];
            if (head.first && !in_burst) begin
               exp_cyc = ((head.ar_cyc > last_rlast) ? head.ar_cyc : last_rlast) + 2 + LAT;
               checkOutput("first_beat_cycle", 32'(cyc), 32'(exp_cyc));
               in_burst = 1;
            end
            checkOutput("rdata", RDATA, head.data);
            checkOutput("rid", 32'(RID), 32'(head.id));
            checkOutput("rlast", 32'(RLAST), 32'(head.last));
            if (RREADY) begin
               hs_count++;
               if (head.last) begin
                  last_rlast = cyc;
                  in_burst   = 0;
               end
               void'(sb.pop_front());
            end
         end
      end else if (in_burst) begin
         checkOutput("gap_inside_burst", 32'(RVALID), 32'd1);
      end
   end

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int hs_base;
      int n;
      int c0;
      bit pattern [7] = '{1, 0, 0, 1, 0, 1, 1};

      rst = 1'b1; ARADDR = '0; ARLEN = '0; ARID = '0; ARVALID = 1'b0; RREADY = 1'b0;
      pl_we = 1'b0; pl_addr = '0; pl_wdata = '0;
      ar0_addr = '0; ar0_len = '0; ar0_id = '0; ar0_valid = 1'b0; r0_ready = 1'b1;

      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("reset_arready", 32'(ARREADY), 32'd0);
      checkOutput("reset_rvalid", 32'(RVALID), 32'd0);
      checkOutput("reset_rlast", 32'(RLAST), 32'd0);
      checkOutput("reset_rid", 32'(RID), 32'd0);
      checkOutput("reset_rdata", RDATA, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      checkOutput("arready_after_reset", 32'(ARREADY), 32'd1);
      @(posedge clk); #1;

      // Basic 4-beat burst, consumer always ready.
      $display("[TB] basic burst");
      for (int i = 0; i < 4; i++) preload(MW'(14'h40 + i), 32'hA0 + 32'(i));
      RREADY = 1'b1;
      applyStimulus(32'h100, 8'd4, 4'd3);
      waitDrain();

      // Same burst under a toggling consumer.
      $display("[TB] backpressure burst");
      RREADY = 1'b0;
      hs_base = hs_count;
      applyStimulus(32'h100, 8'd4, 4'd3);
      n = 0;
      while (!RVALID && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      for (int i = 0; i < 7; i++) begin
         RREADY = pattern[i];
         @(posedge clk); #1;
      end
      RREADY = 1'b1;
      waitDrain();
      checkOutput("toggle_handshakes", 32'(hs_count - hs_base), 32'd4);

      // FIFO fills behind a stalled burst; third request must wait.
      $display("[TB] request queue full");
      for (int i = 0; i < 2; i++) begin
         preload(MW'(14'h10 + i), 32'h110 + 32'(i));
         preload(MW'(14'h20 + i), 32'h120 + 32'(i));
         preload(MW'(14'h30 + i), 32'h130 + 32'(i));
      end
      RREADY = 1'b0;
      applyStimulus(32'h100, 8'd1, 4'd7);
      applyStimulus(32'h040, 8'd2, 4'd1);
      applyStimulus(32'h080, 8'd2, 4'd2);
      @(negedge clk);
      checkOutput("arready_when_full", 32'(ARREADY), 32'd0);
      @(posedge clk); #1;
      fork
         applyStimulus(32'h0C0, 8'd2, 4'd3);
         begin
            repeat (4) @(posedge clk);
            #1 RREADY = 1'b1;
         end
      join
      waitDrain();

      // Address wrap past the top of memory.
      $display("[TB] address wrap");
      preload(14'h3FFE, 32'hE0);
      preload(14'h3FFF, 32'hE1);
      preload(14'h0000, 32'hE2);
      preload(14'h0001, 32'hE3);
      applyStimulus(32'h0000_FFF8, 8'd4, 4'd6);
      waitDrain();

      // ARLEN=0 gives a single beat.
      $display("[TB] zero length");
      preload(14'h0005, 32'hDEAD);
      applyStimulus(32'h14, 8'd0, 4'd2);
      waitDrain();

      // Zero-latency instance: first beat two cycles after the handshake.
      $display("[TB] zero latency build");
      ar0_addr = 32'h14; ar0_len = 8'd0; ar0_id = 4'd9; ar0_valid = 1'b1;
      @(negedge clk);
      checkOutput("lat0_arready", 32'(ar0_ready), 32'd1);
      c0 = cyc;
      @(posedge clk); #1;
      ar0_valid = 1'b0;
      @(negedge clk);
      checkOutput("lat0_rvalid_t1", 32'(r0_valid), 32'd0);
      @(negedge clk);
      checkOutput("lat0_beat_cycle", 32'(cyc - c0), 32'd2);
      checkOutput("lat0_rvalid_t2", 32'(r0_valid), 32'd1);
      checkOutput("lat0_rdata", r0_data, 32'hDEAD);
      checkOutput("lat0_rlast", 32'(r0_last), 32'd1);
      checkOutput("lat0_rid", 32'(r0_id), 32'd9);
      @(negedge clk);
      checkOutput("lat0_rvalid_t3", 32'(r0_valid), 32'd0);
      @(posedge clk); #1;

      // Reset during the second beat of an 8-beat burst with one queued.
      $display("[TB] reset mid-burst");
      for (int i = 0; i < 8; i++) preload(MW'(14'h80 + i), 32'hC0 + 32'(i));
      RREADY = 1'b1;
      hs_base = hs_count;
      applyStimulus(32'h200, 8'd8, 4'd4);
      applyStimulus(32'h040, 8'd2, 4'd5);
      n = 0;
      while (hs_count == hs_base && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      checkOutput("beats_before_reset", 32'(hs_count - hs_base), 32'd1);
      rst = 1'b1;
      RREADY = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      RREADY = 1'b1;
      @(negedge clk);
      checkOutput("rvalid_after_reset", 32'(RVALID), 32'd0);
      checkOutput("rlast_after_reset", 32'(RLAST), 32'd0);
      checkOutput("rdata_after_reset", RDATA, 32'd0);
      checkOutput("arready_after_midreset", 32'(ARREADY), 32'd1);
      hs_base = hs_count;
      repeat (20) @(posedge clk);
      #1;
      checkOutput("no_beats_after_reset", 32'(hs_count - hs_base), 32'd0);
      applyStimulus(32'h200, 8'd8, 4'd4);
      waitDrain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
